// File: rtl/fastram_pkg.sv
// fastram_pkg: FSM states and bus constants for the fast-RAM front end.
// BERR_HOLD exists only when FASTRAM_BERR_EN is defined.
package fastram_pkg;
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;
  localparam logic ASSERTED = 1'b0;
  localparam logic NEGATED = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    IGNORE,
    WAIT_MEM,
    ACK,
    RELEASE
`ifdef FASTRAM_BERR_EN
    , BERR_HOLD
`endif
  } state_t;
endpackage

// File: rtl/fastram_bus_ctrl_if.sv
// fastram_bus_ctrl_if: CPU bus, SDRAM controller handshake and decode outputs of the fast-RAM front end.
interface fastram_bus_ctrl_if;
  logic as;
  logic uds;
  logic lds;
  logic rw;
  logic [2:0] fc;
  logic [23:1] a;
  logic valid;
  logic wterm;
  logic access;
  logic hit;
  logic dtack;
  logic dtack_oe;
  logic berr;
  logic [1:0] ds_s;
  modport master(
    output as, uds, lds, rw, fc, a, valid, wterm,
    input access, hit, dtack, dtack_oe, berr, ds_s
  );
  modport slave(
    input as, uds, lds, rw, fc, a, valid, wterm,
    output access, hit, dtack, dtack_oe, berr, ds_s
  );
endinterface

// File: rtl/fastram_sync.sv
// fastram_sync: N-stage, 5-bit synchroniser for async strobes; every stage resets to 1 (idle level).
module fastram_sync #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d,
  output logic [4:0] q
);
  logic [N*5-1:0] s;
  always_ff @(posedge clk)
    s <= rst ? '1 : {s[N*5-6:0], d};
  assign q = s[N*5-1 -: 5];
endmodule

// File: rtl/fastram_bus_ctrl.sv
// fastram_bus_ctrl: 68000 bus front end for the fast-RAM SDRAM controller (decode, ACCESS request, DTACK).
// Define FASTRAM_BERR_EN to add the WAIT_MEM watchdog that raises BERR.
module fastram_bus_ctrl
  import fastram_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h400000,
  parameter int SIZE_LOG2 = 22,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  fastram_bus_ctrl_if.slave bus
);
  localparam logic [23:0] WIN_MASK = ~((24'd1 << SIZE_LOG2) - 24'd1);
  logic [4:0] sync_q;
  logic as_s, valid_s, wterm_s, take, rw_q, rw_n;
  logic access_n, hit_n, dtack_n, oe_n, berr_n;
  state_t state, state_n;
  fastram_sync #(.N(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d({bus.as, bus.uds, bus.lds, bus.valid, bus.wterm}),
    .q(sync_q)
  );
  assign {as_s, bus.ds_s, valid_s, wterm_s} = sync_q;
  assign take = !as_s && ((bus.a ^ BASE_ADDR[23:1]) & WIN_MASK[23:1]) == '0 && bus.fc != FC_CPU_SPACE;
`ifdef FASTRAM_BERR_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || state != WAIT_MEM) ? '0 : cnt + 1'b1;
`endif
  // Outputs are registered: next values start from the current ones and only change on transitions.
  always_comb begin
    state_n = state;
    rw_n = rw_q;
    access_n = bus.access;
    hit_n = bus.hit;
    dtack_n = bus.dtack;
    oe_n = bus.dtack_oe;
    berr_n = bus.berr;
    case (state)
      IDLE: begin
        rw_n = as_s ? rw_q : bus.rw;
        state_n = as_s ? IDLE : take ? WAIT_MEM : IGNORE;
        access_n = take ? ASSERTED : NEGATED;
        hit_n = take;
      end
      IGNORE: state_n = as_s ? IDLE : IGNORE;
      WAIT_MEM:
        if (as_s) begin
          access_n = NEGATED;
          hit_n = 1'b0;
          state_n = RELEASE;
        end else if (rw_q ? valid_s == ASSERTED : wterm_s == ASSERTED) begin
          dtack_n = ASSERTED;
          oe_n = 1'b1;
          state_n = ACK;
        end
`ifdef FASTRAM_BERR_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          berr_n = ASSERTED;
          access_n = NEGATED;
          hit_n = 1'b0;
          state_n = BERR_HOLD;
        end
      BERR_HOLD:
        if (as_s) begin
          berr_n = NEGATED;
          state_n = RELEASE;
        end
`endif
      ACK:
        if (as_s) begin
          access_n = NEGATED;
          hit_n = 1'b0;
          dtack_n = NEGATED;
          state_n = RELEASE;
        end
      RELEASE: begin
        oe_n = 1'b0;
        berr_n = NEGATED;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rw_q <= 1'b1;
      bus.access <= NEGATED;
      bus.hit <= 1'b0;
      bus.dtack <= NEGATED;
      bus.dtack_oe <= 1'b0;
      bus.berr <= NEGATED;
    end else begin
      state <= state_n;
      rw_q <= rw_n;
      bus.access <= access_n;
      bus.hit <= hit_n;
      bus.dtack <= dtack_n;
      bus.dtack_oe <= oe_n;
      bus.berr <= berr_n;
    end
endmodule

// File: tb/tb_fastram_bus_ctrl.sv
// tb_fastram_bus_ctrl: randomized bus cycles against a timing/decode reference model for fastram_bus_ctrl.
// Define FASTRAM_BERR_EN to also exercise the watchdog.
module tb_fastram_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int dt_low = 0, acc_low = 0, hit_hi = 0, oe_hi = 0, berr_low = 0, hi_run = 0, last_run = 0;
  fastram_bus_ctrl_if bus();
  fastram_bus_ctrl dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (!bus.dtack) dt_low++;
    if (!bus.access) acc_low++;
    if (bus.hit) hit_hi++;
    if (bus.dtack_oe) oe_hi++;
    if (!bus.berr) berr_low++;
    if (bus.access) hi_run++;
    else begin
      if (hi_run != 0) last_run = hi_run;
      hi_run = 0;
    end
  end
  function automatic logic [4:0] outs();
    return {bus.access, bus.hit, bus.dtack, bus.dtack_oe, bus.berr};
  endfunction
  function automatic logic sig(input int w);
    return w == 0 ? bus.access : w == 1 ? bus.dtack : bus.berr;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_sig(input int w, input logic v, input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (sig(w) !== v && n < lim);
    if (sig(w) !== v) n = 9999;
  endtask
  task automatic idle_bus();
    bus.as = 1'b1;
    bus.uds = 1'b1;
    bus.lds = 1'b1;
    bus.valid = 1'b1;
    bus.wterm = 1'b1;
  endtask
  // Model: hit = address inside [0x400000,0x800000) and FC!=7; every strobe takes 3 edges to act.
  task automatic txn(input logic [23:0] addr, input logic rd, input logic [2:0] fc,
                     input int rep, input int hold, input int mode, input int gap);
    int n, d0, a0, h0, o0;
    logic [1:0] ds;
    logic exp_hit;
    exp_hit = addr >= 24'h400000 && addr < 24'h800000 && fc != 3'd7;
    ds = rd ? 2'b00 : 2'($urandom_range(2));
    repeat (gap) @(posedge clk);
    #1;
    d0 = dt_low; a0 = acc_low; h0 = hit_hi; o0 = oe_hi;
    bus.a = addr[23:1];
    bus.rw = rd;
    bus.fc = fc;
    {bus.uds, bus.lds} = ds;
    bus.as = 1'b0;
    if (!exp_hit) begin
      repeat (hold + 4) @(posedge clk);
      #1;
      chk("ds_sync", 32'(bus.ds_s), 32'(ds));
      idle_bus();
      repeat (4) @(posedge clk);
      #1;
      chk("miss_quiet", (acc_low - a0) + (hit_hi - h0) + (oe_hi - o0) + (dt_low - d0), 0);
      return;
    end
    wait_sig(0, 1'b0, 20, n);
    #1;
    chk("acc_lat", n, 3);
    chk("acc_gap", 32'(last_run >= 2), 1);
    chk("hit_on", 32'(bus.hit), 1);
    chk("ds_sync", 32'(bus.ds_s), 32'(ds));
    if (mode == 0) begin
      @(posedge clk);
      #1;
      if (rd) bus.wterm = 1'b0;
      else bus.valid = 1'b0;
      repeat (rep + 4) @(posedge clk);
      #1;
      chk("no_wrong_ack", dt_low - d0, 0);
      bus.valid = !rd;
      bus.wterm = rd;
      wait_sig(1, 1'b0, 20, n);
      chk("dtack_lat", n, 3);
      chk("ack_outs", 32'({bus.access, bus.hit, bus.dtack_oe}), 32'b011);
      repeat (hold) @(posedge clk);
      #1;
      idle_bus();
      wait_sig(1, 1'b1, 20, n);
      chk("dtack_rel", n, 3);
      chk("rel_outs", 32'({bus.access, bus.hit, bus.dtack_oe}), 32'b101);
      @(posedge clk);
      @(negedge clk);
      chk("oe_off", 32'(bus.dtack_oe), 0);
    end else begin
      repeat (hold) @(posedge clk);
      #1;
      idle_bus();
      if (mode == 2) begin
        if (rd) bus.valid = 1'b0;
        else bus.wterm = 1'b0;
      end
      wait_sig(0, 1'b1, 20, n);
      chk("abort_lat", n, 3);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_ack", (dt_low - d0) + (oe_hi - o0), 0);
      idle_bus();
    end
  endtask
  initial begin
    int n;
    bus.as = 1'b0;
    bus.uds = 1'b0;
    bus.lds = 1'b0;
    bus.valid = 1'b0;
    bus.wterm = 1'b0;
    bus.rw = 1'b1;
    bus.fc = 3'd5;
    bus.a = 23'h200008;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_outs", 32'(outs()), 32'b10101);
    end
    @(posedge clk);
    #1;
    idle_bus();
    rst = 1'b0;
    txn(24'h400010, 1'b1, 3'd5, 0, 3, 0, 3);
    txn(24'h7FFFFE, 1'b0, 3'd1, 8, 2, 0, 2);
    txn(24'h200000, 1'b1, 3'd5, 0, 3, 0, 3);
    txn(24'h400000, 1'b1, 3'd7, 0, 3, 0, 3);
    txn(24'h400100, 1'b1, 3'd6, 0, 4, 1, 2);
    txn(24'h3FFFFE, 1'b0, 3'd1, 0, 2, 0, 2);
    txn(24'h800000, 1'b1, 3'd2, 0, 2, 0, 2);
    txn(24'h400020, 1'b0, 3'd1, 2, 3, 2, 2);
    for (int i = 0; i < 40; i++) begin
      logic [23:0] ad;
      logic [2:0] f;
      ad = 24'($urandom) & 24'hFFFFFE;
      if ($urandom_range(3) != 0) ad[23:22] = 2'b01;
      f = ($urandom_range(7) == 0) ? 3'd7 : 3'($urandom_range(6));
      txn(ad, 1'($urandom), f, $urandom_range(8), $urandom_range(1, 5),
          $urandom_range(2), $urandom_range(2, 5));
    end
    // Reset in the middle of an acknowledged read drops the cycle at once.
    @(posedge clk);
    #1;
    bus.a = 23'h200040;
    bus.rw = 1'b1;
    bus.fc = 3'd5;
    bus.as = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("mid_acc_lat", n, 3);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    wait_sig(1, 1'b0, 20, n);
    chk("mid_dtack_lat", n, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bus();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_outs", 32'(outs()), 32'b10101);
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef FASTRAM_BERR_EN
    repeat (2) @(posedge clk);
    #1;
    bus.a = 23'h200080;
    bus.rw = 1'b1;
    bus.fc = 3'd5;
    bus.as = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("berr_acc_lat", n, 3);
    wait_sig(2, 1'b0, 400, n);
    chk("berr_timeout", n, 255);
    chk("berr_outs", 32'({bus.access, bus.dtack, bus.dtack_oe}), 32'b110);
    @(posedge clk);
    #1;
    idle_bus();
    wait_sig(2, 1'b1, 20, n);
    chk("berr_rel", n, 3);
    repeat (2) @(posedge clk);
    #1;
    txn(24'h400200, 1'b1, 3'd5, 0, 2, 0, 2);
`else
    chk("berr_tied", berr_low, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
